gcd_control: RTL
================

# gcd_control

Control FSM for the subtractive-GCD data path. It sequences the operand load, the swap and subtract steps, and termination by driving the mux selects and register enables (`Asel`, `Aen`, `Bsel`, `Ben`) from the status flags `B_eq_0` and `A_lessThan_B`. It also gives the surrounding logic a start/busy/done handshake. Together with the data path it forms the complete GCD unit, and the result is read from the data path `Result` port.

## Interface

- `CNT_BITS`, default 8: width of the iteration counter. Used only when `GCD_ITER_COUNT_EN` is defined.

- `clk`, input, 1: clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a new computation. Sampled only in IDLE.
- `B_eq_0`, input, 1: data path status, B register == 0.
- `A_lessThan_B`, input, 1: data path status, A < B (unsigned).
- `Asel`, output, 2: A mux select. 0 = In_A, 1 = A−B, 2 = B. 3 is never driven.
- `Aen`, output, 1: A register load enable.
- `Bsel`, output, 1: B mux select. 0 = A, 1 = In_B.
- `Ben`, output, 1: B register load enable.
- `busy`, output, 1: high in CALC and DONE.
- `done`, output, 1: one-cycle pulse. Data path `Result` holds the GCD in this cycle.
- `iter_count`, output, CNT_BITS: number of swap/subtract steps. Present only with `GCD_ITER_COUNT_EN`.

## Operation

- States: IDLE, CALC, DONE. The state register is 2 bits. Unused encodings go to IDLE on the next edge.
- Control outputs are combinational from the state and the status inputs. The status inputs come from data path registers, so there is no combinational loop.
- **IDLE**
  - `start`=0: `Aen`=`Ben`=0, `Asel`=0, `Bsel`=0.
  - `start`=1: load both operands with `Asel`=0, `Aen`=1, `Bsel`=1, `Ben`=1. Next state is CALC.
- **CALC**, priority order:
  1. `B_eq_0`=1: `Aen`=`Ben`=0. Next state is DONE.
  2. `A_lessThan_B`=1 (swap): `Asel`=2, `Aen`=1, `Bsel`=0, `Ben`=1. Stay in CALC.
  3. Otherwise (subtract): `Asel`=1, `Aen`=1, `Ben`=0, `Bsel`=0. Stay in CALC.
- **DONE**: `done`=1, all enables 0. Next state is IDLE unconditionally.
- Select values while their enable is 0: `Asel`=0, `Bsel`=0. These are don't-care to the data path but fixed for verification.
- `start` is ignored in CALC and DONE. It is not queued.
- The data path operands are unsigned. The A−B subtraction is only issued when A ≥ B, so it never wraps.

## Timing

- Reset values: state IDLE, `Asel`=0, `Aen`=0, `Bsel`=0, `Ben`=0, `busy`=0, `done`=0, `iter_count`=0.
- Reset does not clear the data path registers; they keep their contents.
- Reset takes effect at the next edge from any state, including mid-CALC. Enables are low from the cycle after that edge.
- Let the start-sampling edge be E0 and k the number of swap/subtract steps.
  - `done` is high in cycle k+2 after E0.
  - `busy` is high in cycles 1 through k+2.
- The earliest new `start` is sampled on the edge that ends the cycle after `done`, i.e. the first IDLE cycle.
- `Result` stays valid after `done` until the next load, because `Aen`=0 in IDLE without `start`.
- `reset` and `start` asserted together: `reset` wins and no load is issued.

## Configuration

- `GCD_ITER_COUNT_EN` defined:
  - The `iter_count` port exists.
  - It clears to 0 on the load cycle.
  - It increments by 1 on each CALC swap or subtract step.
  - It saturates at 2^CNT_BITS−1 and holds its value through DONE and IDLE until the next load.
- `GCD_ITER_COUNT_EN` undefined: the port and the counter are absent, and the FSM behaviour is identical.

## Test plan

- Reset in any state -> all outputs at reset values next cycle; `start`=1 held during reset -> no `Aen`/`Ben` pulse.
- In_A=12, In_B=8, pulse `start` -> step sequence sub, swap, sub, sub, swap; `done` in cycle 7; `Result`=4; `iter_count`=5.
- In_A=9, In_B=0 -> `done` in cycle 2, `Result`=9, `iter_count`=0.
- In_A=0, In_B=5 -> one swap; `done` in cycle 3, `Result`=5.
- `start` re-pulsed mid-CALC and in the DONE cycle -> ignored, no load; `start` in the following IDLE cycle -> new load.
- `reset` asserted in the 3rd CALC cycle of the 12/8 run -> IDLE next edge, no `done`; `CNT_BITS`=2 with In_A=31, In_B=1 -> `iter_count` saturates at 3, `Result`=1.

Source files
------------

// File: rtl/gcd_control.sv
// Control FSM for the subtractive-GCD data path with a start/busy/done handshake.
// Defining GCD_ITER_COUNT_EN adds the saturating iter_count output.
module gcd_control #(
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                B_eq_0,
  input  logic                A_lessThan_B,
  output logic [1:0]          Asel,
  output logic                Aen,
  output logic                Bsel,
  output logic                Ben,
  output logic                busy,
  output logic                done
`ifdef GCD_ITER_COUNT_EN
  ,
  output logic [CNT_BITS-1:0] iter_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode; a load is suppressed while reset is high
  always_comb begin
    next_state = IDLE;
    Asel       = 2'd0;
    Aen        = 1'b0;
    Bsel       = 1'b0;
    Ben        = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start && !reset) begin
          Aen        = 1'b1;
          Bsel       = 1'b1;
          Ben        = 1'b1;
          next_state = CALC;
        end else begin
          next_state = IDLE;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (B_eq_0) begin
          next_state = DONE;
        end else if (A_lessThan_B) begin
          Asel       = 2'd2;
          Aen        = 1'b1;
          Ben        = 1'b1;
          next_state = CALC;
        end else begin
          Asel       = 2'd1;
          Aen        = 1'b1;
          next_state = CALC;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

`ifdef GCD_ITER_COUNT_EN
  logic                load;
  logic                step;
  logic [CNT_BITS-1:0] iter_cnt;

  assign load = (state == IDLE) && start && !reset;
  assign step = (state == CALC) && !B_eq_0;

  // Step counter: cleared on load, saturates at all-ones, held otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      iter_cnt <= '0;
    end else if (load) begin
      iter_cnt <= '0;
    end else if (step && (iter_cnt != {CNT_BITS{1'b1}})) begin
      iter_cnt <= iter_cnt + CNT_BITS'(1);
    end else begin
      iter_cnt <= iter_cnt;
    end
  end

  assign iter_count = iter_cnt;
`endif

endmodule
